// File: rtl/gpio_bus_pkg.sv
// Shared definitions for masters that write the GPIO peripheral over the 64-bit bus:
// device/sub-address constants, sequencer state codes and the address builder.
package gpio_bus_pkg;

  localparam logic [7:0] GPIO_ADDR = 8'h05;

  localparam logic [2:0] SCREEN_LO = 3'd1;
  localparam logic [2:0] SCREEN_HI = 3'd2;
  localparam logic [2:0] SEVSEG    = 3'd3;

  typedef logic [2:0] seq_state_t;

  localparam seq_state_t ST_IDLE   = 3'd0;
  localparam seq_state_t ST_REQ    = 3'd1;
  localparam seq_state_t ST_BEAT   = 3'd2;
  localparam seq_state_t ST_GAP    = 3'd3;
  localparam seq_state_t ST_FINISH = 3'd4;

  // Device byte lands in the top byte, sub-address in the bottom bits.
  function automatic logic [63:0] dev_addr(input logic [7:0] dev, input logic [2:0] sub);
    return {dev, 53'b0, sub};
  endfunction

endpackage

// File: rtl/gpio_write_sequencer.sv
// Bus master that latches a screen frame plus seven-segment code and pushes them to
// the GPIO peripheral as up to three write beats once the arbiter grants the bus.
module gpio_write_sequencer #(
  parameter logic [7:0]  GPIO_ADDR  = gpio_bus_pkg::GPIO_ADDR,
  parameter int unsigned GAP_CYCLES = 0
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         start,
  input  logic [127:0] frame_data,
  input  logic [3:0]   sevseg,
  input  logic [2:0]   update_mask,
  output logic         bus_req,
  input  logic         bus_grant,
  output logic [63:0]  address,
  output logic [63:0]  data_out,
  output logic         data_oe,
  output logic         write,
  output logic         busy,
  output logic         done,
  output logic         error
);
  import gpio_bus_pkg::*;

  seq_state_t   state_q, state_d;
  logic [1:0]   beat_q, beat_d;
  logic [2:0]   mask_q, mask_d;
  logic [127:0] frame_q, frame_d;
  logic [3:0]   sev_q, sev_d;
  logic [3:0]   gap_cnt_q, gap_cnt_d;
  logic         done_q, done_d;
  logic         error_q, error_d;

  logic [1:0]   first_idx;
  logic         nxt_valid;
  logic [1:0]   nxt_idx;
  logic [2:0]   beat_sub;
  logic [63:0]  beat_data;
  logic         in_beat;
  logic         on_bus;

  // Lowest enabled beat of the incoming mask, and next enabled beat above the current one.
  always_comb begin
    first_idx = 2'd0;
    for (int i = 2; i >= 0; i--) begin
      if (update_mask[i]) first_idx = 2'(i);
    end
    nxt_valid = 1'b0;
    nxt_idx   = beat_q;
    for (int i = 2; i >= 0; i--) begin
      if (mask_q[i] && (i > int'(beat_q))) begin
        nxt_valid = 1'b1;
        nxt_idx   = 2'(i);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    mask_d    = mask_q;
    frame_d   = frame_q;
    sev_d     = sev_q;
    gap_cnt_d = gap_cnt_q;
    done_d    = 1'b0;
    error_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (update_mask != 3'b000) begin
            mask_d  = update_mask;
            frame_d = frame_data;
            sev_d   = sevseg;
            beat_d  = first_idx;
            state_d = ST_REQ;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      ST_REQ: begin
        if (bus_grant) state_d = ST_BEAT;
      end
      ST_BEAT: begin
        // The arbiter must hold the grant until bus_req falls; losing it aborts the update.
        if (!bus_grant) begin
          error_d = 1'b1;
          state_d = ST_IDLE;
        end else if (nxt_valid) begin
          beat_d = nxt_idx;
          if (GAP_CYCLES > 0) begin
            gap_cnt_d = 4'(GAP_CYCLES - 1);
            state_d   = ST_GAP;
          end else begin
            state_d = ST_BEAT;
          end
        end else begin
          done_d  = 1'b1;
          state_d = ST_FINISH;
        end
      end
      ST_GAP: begin
        if (!bus_grant) begin
          error_d = 1'b1;
          state_d = ST_IDLE;
        end else if (gap_cnt_q == 4'd0) begin
          state_d = ST_BEAT;
        end else begin
          gap_cnt_d = gap_cnt_q - 4'd1;
        end
      end
      ST_FINISH: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      beat_q    <= 2'd0;
      mask_q    <= 3'b000;
      frame_q   <= '0;
      sev_q     <= 4'd0;
      gap_cnt_q <= 4'd0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      beat_q    <= beat_d;
      mask_q    <= mask_d;
      frame_q   <= frame_d;
      sev_q     <= sev_d;
      gap_cnt_q <= gap_cnt_d;
      done_q    <= done_d;
      error_q   <= error_d;
    end
  end

  // Bus outputs decode registered state only, so they hold for the whole beat cycle.
  always_comb begin
    case (beat_q)
      2'd0: begin
        beat_sub  = SCREEN_LO;
        beat_data = frame_q[63:0];
      end
      2'd1: begin
        beat_sub  = SCREEN_HI;
        beat_data = frame_q[127:64];
      end
      default: begin
        beat_sub  = SEVSEG;
        beat_data = {60'b0, sev_q};
      end
    endcase
  end

  assign in_beat  = (state_q == ST_BEAT);
  assign on_bus   = (state_q == ST_REQ) || (state_q == ST_BEAT) || (state_q == ST_GAP);

  assign address  = in_beat ? dev_addr(GPIO_ADDR, beat_sub) : 64'd0;
  assign data_out = in_beat ? beat_data : 64'd0;
  assign data_oe  = in_beat;
  assign write    = in_beat;
  assign bus_req  = on_bus;
  assign busy     = on_bus;
  assign done     = done_q;
  assign error    = error_q;

endmodule

// File: tb/tb_gpio_write_sequencer.sv
// Scoreboard bench: two sequencers (no gap, two-cycle gap) driven one at a time;
// expected bus events are predicted per update and checked by an independent monitor.
module tb_gpio_write_sequencer;

  typedef struct {
    int          inst;
    int          kind;   // 0 write, 1 done, 2 error
    int          cyc;
    logic [63:0] addr;
    logic [63:0] data;
    int          busy;
  } ev_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [1:0]   start_s = 2'b00;
  logic [1:0]   grant_s = 2'b00;
  logic [127:0] frame = '0;
  logic [3:0]   sev = 4'd0;
  logic [2:0]   mask = 3'b000;
  logic [1:0]   bus_req_s, data_oe_s, write_s, busy_s, done_s, error_s;
  logic [63:0]  addr_s [2];
  logic [63:0]  data_s [2];

  int  cyc = 0;
  int  checks = 0;
  int  failures = 0;
  int  bcnt [2] = '{0, 0};
  ev_t exp_q [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    gpio_write_sequencer #(.GPIO_ADDR(8'h05), .GAP_CYCLES(gi * 2)) u_dut (
      .clock(clk), .reset(rst), .start(start_s[gi]), .frame_data(frame), .sevseg(sev),
      .update_mask(mask), .bus_req(bus_req_s[gi]), .bus_grant(grant_s[gi]),
      .address(addr_s[gi]), .data_out(data_s[gi]), .data_oe(data_oe_s[gi]),
      .write(write_s[gi]), .busy(busy_s[gi]), .done(done_s[gi]), .error(error_s[gi])
    );
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: invariants every cycle, and every write/done/error matched against the queue.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      int  kind;
      ev_t e;
      chk("oe_tracks_write", data_oe_s[i], write_s[i]);
      chk("req_tracks_busy", bus_req_s[i], busy_s[i]);
      if (busy_s[i]) bcnt[i]++;
      if (write_s[i] || done_s[i] || error_s[i]) begin
        kind = write_s[i] ? 0 : (done_s[i] ? 1 : 2);
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_event: inst %0d kind %0d at cycle %0d, none required", i, kind, cyc);
        end else begin
          e = exp_q.pop_front();
          chk("ev_inst", i, e.inst);
          chk("ev_kind", kind, e.kind);
          chk("ev_cycle", cyc, e.cyc);
          if (kind == 0) begin
            chk("wr_addr", addr_s[i], e.addr);
            chk("wr_data", data_s[i], e.data);
          end else begin
            chk("busy_cycles", bcnt[i], e.busy);
            bcnt[i] = 0;
          end
        end
      end
    end
    if (rst) bcnt = '{0, 0};
  end

  task automatic at_cycle(input int c);
    while (cyc < c) @(negedge clk);
    #1;
  endtask

  task automatic push_ev(input int inst, input int kind, input int c,
                         input logic [63:0] a, input logic [63:0] d, input int b);
    ev_t e;
    e.inst = inst; e.kind = kind; e.cyc = c; e.addr = a; e.data = d; e.busy = b;
    exp_q.push_back(e);
  endtask

  // One update: predict the bus events from the rules, then drive start/grant/reset by cycle.
  task automatic run_txn(input int inst, input logic [2:0] m, input logic [127:0] f,
                         input logic [3:0] s, input int gdelay, input int drop_k,
                         input int rst_k, input bit poke_busy, input bit poke_finish);
    int c0, w, n, last, endc, gap, sub;
    int subs [$];
    logic [63:0] d;
    gap = inst * 2;
    at_cycle(cyc + 1);
    c0 = cyc;
    frame = f; sev = s; mask = m;
    start_s[inst] = 1'b1;
    grant_s[inst] = (gdelay == 0);
    for (int b = 0; b < 3; b++) if (m[b]) subs.push_back(b + 1);
    last = c0;
    if (subs.size() == 0) begin
      endc = c0 + 1;
      push_ev(inst, 1, endc, 64'd0, 64'd0, 0);
    end else begin
      w = (c0 + gdelay + 1 > c0 + 2) ? c0 + gdelay + 1 : c0 + 2;
      n = subs.size();
      if (drop_k > 0 && drop_k < n) n = drop_k;
      if (rst_k > 0 && rst_k < n) n = rst_k;
      for (int k = 0; k < n; k++) begin
        sub = subs[k];
        d = (sub == 1) ? f[63:0] : (sub == 2) ? f[127:64] : {60'd0, s};
        push_ev(inst, 0, w + k * (gap + 1), 64'h0500_0000_0000_0000 | 64'(sub), d, 0);
      end
      last = w + (n - 1) * (gap + 1);
      endc = last + 1;
      if (rst_k == 0) push_ev(inst, (drop_k > 0) ? 2 : 1, endc, 64'd0, 64'd0, endc - c0 - 1);
    end
    for (int t = c0 + 1; t <= endc + 2; t++) begin
      at_cycle(t);
      if (t == c0 + 1) start_s[inst] = 1'b0;
      if (gdelay > 0 && t == c0 + gdelay) grant_s[inst] = 1'b1;
      if (poke_busy && t == c0 + 2) begin
        start_s[inst] = 1'b1;
        mask = 3'b111;
        frame = {$urandom, $urandom, $urandom, $urandom};
        sev = 4'($urandom);
      end
      if (poke_busy && t == c0 + 3) start_s[inst] = 1'b0;
      if (drop_k > 0 && t == last) grant_s[inst] = 1'b0;
      if (rst_k > 0 && t == last) rst = 1'b1;
      if (rst_k > 0 && t == last + 1) begin
        chk("rst_bus_req", bus_req_s[inst], 1'b0);
        chk("rst_write", write_s[inst], 1'b0);
        chk("rst_data_oe", data_oe_s[inst], 1'b0);
        chk("rst_busy", busy_s[inst], 1'b0);
        chk("rst_address", addr_s[inst], 64'd0);
        chk("rst_data", data_s[inst], 64'd0);
        rst = 1'b0;
      end
      if (poke_finish && t == endc) begin
        start_s[inst] = 1'b1;
        mask = 3'b111;
      end
      if (poke_finish && t == endc + 1) start_s[inst] = 1'b0;
    end
    chk("queue_drained", exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    int inst, gd, dk;
    logic [2:0] m;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("reset_bus_req", bus_req_s[i], 1'b0);
      chk("reset_address", addr_s[i], 64'd0);
      chk("reset_data_out", data_s[i], 64'd0);
      chk("reset_oe_write", {data_oe_s[i], write_s[i]}, 2'b00);
      chk("reset_busy_done_error", {busy_s[i], done_s[i], error_s[i]}, 3'b000);
    end
    #1 rst = 1'b0;

    run_txn(0, 3'b111, {{16{4'hA}}, {16{4'h5}}}, 4'h9, 0, 0, 0, 1'b0, 1'b0);
    run_txn(1, 3'b101, {$urandom, $urandom, $urandom, $urandom}, 4'h3, 0, 0, 0, 1'b0, 1'b0);
    run_txn(0, 3'b111, {$urandom, $urandom, $urandom, $urandom}, 4'h6, 6, 0, 0, 1'b1, 1'b0);
    run_txn(0, 3'b111, {$urandom, $urandom, $urandom, $urandom}, 4'hC, 0, 1, 0, 1'b0, 1'b0);
    run_txn(1, 3'b111, {$urandom, $urandom, $urandom, $urandom}, 4'h1, 0, 2, 0, 1'b0, 1'b0);
    run_txn(0, 3'b000, {$urandom, $urandom, $urandom, $urandom}, 4'h2, 0, 0, 0, 1'b0, 1'b0);
    run_txn(1, 3'b000, {$urandom, $urandom, $urandom, $urandom}, 4'h2, 0, 0, 0, 1'b0, 1'b0);
    run_txn(0, 3'b111, {$urandom, $urandom, $urandom, $urandom}, 4'h7, 0, 0, 2, 1'b0, 1'b0);
    run_txn(0, 3'b111, {$urandom, $urandom, $urandom, $urandom}, 4'hE, 0, 0, 0, 1'b0, 1'b1);
    run_txn(1, 3'b110, {$urandom, $urandom, $urandom, $urandom}, 4'hF, 3, 0, 0, 1'b1, 1'b0);

    for (int r = 0; r < 40; r++) begin
      inst = int'($urandom_range(1, 0));
      m    = 3'($urandom);
      gd   = int'($urandom_range(4, 0));
      dk   = ($urandom_range(5, 0) == 0) ? int'($urandom_range(3, 1)) : 0;
      run_txn(inst, m, {$urandom, $urandom, $urandom, $urandom}, 4'($urandom), gd, dk, 0,
              (m != 3'b000) && ($urandom_range(1, 0) == 1), 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
